// File: rtl/mem_lsu_ctrl.sv
// Load/store sequencer between the LSU and a combinational-read, negedge-commit data memory.
// Handles size/sign extension, sub-word read-modify-write, error checks and write settling.
module mem_lsu_ctrl #(
   parameter int unsigned MEM_SIZE = 1048576,
   parameter int unsigned WIDTH    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic [31:0]      mem_raddr,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             mem_wen,
   output logic [31:0]      mem_waddr,
   output logic [WIDTH-1:0] mem_wdata
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WR_ISSUE  = 2'd1,
      WR_SETTLE = 2'd2,
      RESP      = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             wen_q, wen_d;
   logic [31:0]      waddr_q, waddr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;

   logic [31:0]      req_addr_al;
   logic             req_err;

   // Shift the addressed lane(s) down and extend to a full word.
   function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] word,
                                                    input logic [1:0]       off,
                                                    input logic [2:0]       f3);
      logic [WIDTH-1:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
         F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
         F3_BU:   load_extend = {24'd0, sh[7:0]};
         F3_HU:   load_extend = {16'd0, sh[15:0]};
         default: load_extend = word;
      endcase
   endfunction

   // Replace only the stored lane(s) of the word read at accept time.
   function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] old_word,
                                                    input logic [WIDTH-1:0] wdata,
                                                    input logic [1:0]       off,
                                                    input logic [2:0]       f3);
      logic [WIDTH-1:0] mask;
      logic [WIDTH-1:0] ins;
      case (f3)
         F3_B: begin
            mask = 32'h0000_00FF << {off, 3'b000};
            ins  = {24'd0, wdata[7:0]} << {off, 3'b000};
         end
         F3_H: begin
            mask = 32'h0000_FFFF << {off, 3'b000};
            ins  = {16'd0, wdata[15:0]} << {off, 3'b000};
         end
         default: begin
            mask = '1;
            ins  = wdata;
         end
      endcase
      store_merge = (old_word & ~mask) | (ins & mask);
   endfunction

   function automatic logic req_error(input logic        we,
                                      input logic [2:0]  f3,
                                      input logic [31:0] addr);
      logic legal_f3;
      logic misal;
      logic oor;
      if (we) legal_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else    legal_f3 = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                         (f3 == F3_BU) || (f3 == F3_HU);
      misal = (((f3 == F3_H) || (f3 == F3_HU)) && addr[0]) ||
              ((f3 == F3_W) && (addr[1:0] != 2'b00));
      // 33-bit sum so addresses near 2^32 cannot wrap into range.
      oor = ({1'b0, addr[31:2], 2'b00} + 33'd3) >= 33'(MEM_SIZE);
      req_error = !legal_f3 || misal || oor;
   endfunction

   assign req_addr_al = {req_addr[31:2], 2'b00};
   assign req_err     = req_error(req_we, req_funct3, req_addr);

   assign mem_raddr  = req_addr_al;
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_wen    = wen_q;
   assign mem_waddr  = waddr_q;
   assign mem_wdata  = wdata_q;

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESP;
               end else if (req_we) begin
                  // Write word is built now from the read port, so WR_ISSUE only drives it.
                  err_d   = 1'b0;
                  rdata_d = '0;
                  wen_d   = 1'b1;
                  waddr_d = req_addr_al;
                  wdata_d = store_merge(mem_rdata, req_wdata, req_addr[1:0], req_funct3);
                  state_d = WR_ISSUE;
               end else begin
                  err_d   = 1'b0;
                  rdata_d = load_extend(mem_rdata, req_addr[1:0], req_funct3);
                  state_d = RESP;
               end
            end
         end
         WR_ISSUE:  state_d = WR_SETTLE;
         WR_SETTLE: state_d = RESP;
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl with a small negedge-commit memory model.
module tb_mem_lsu_ctrl;

   localparam int unsigned MEM_SIZE = 1048576;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_raddr, mem_rdata;
   logic        mem_wen;
   logic [31:0] mem_waddr, mem_wdata;

   int checks   = 0;
   int failures = 0;

   mem_lsu_ctrl #(.MEM_SIZE(MEM_SIZE), .WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   // Memory model: write inputs registered on posedge, committed on the following negedge.
   logic [31:0] mem [0:1023];
   logic        w_pend = 1'b0;
   logic [31:0] w_addr = '0, w_data = '0;
   int          wen_cnt = 0;
   int          wen_consec = 0;
   logic        wen_prev = 1'b0;
   logic [31:0] last_waddr = '0, last_wdata = '0;

   assign mem_rdata = mem[mem_raddr[11:2]];

   always @(posedge clk) begin
      w_pend   <= mem_wen;
      w_addr   <= mem_waddr;
      w_data   <= mem_wdata;
      wen_prev <= mem_wen;
      if (mem_wen) begin
         wen_cnt    <= wen_cnt + 1;
         last_waddr <= mem_waddr;
         last_wdata <= mem_wdata;
         if (wen_prev) wen_consec <= wen_consec + 1;
      end
   end

   always @(negedge clk) begin
      if (w_pend) mem[w_addr[11:2]] <= w_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, wait (bounded) for the response, check it and accept it.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_wens);
      int lat;
      int w0;
      chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
      w0         = wen_cnt;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      step();
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".rdata"}, resp_rdata, exp_rd);
      chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk({tag, ".resp_drop"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, ".wen_pulses"}, 32'(wen_cnt - w0), 32'(exp_wens));
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0107;
      req_wdata  = '0;
      resp_ready = 1'b0;
      repeat (3) step();

      chk("rst.req_ready",  {31'd0, req_ready},  32'd1);
      chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst.resp_rdata", resp_rdata, 32'd0);
      chk("rst.resp_err",   {31'd0, resp_err},   32'd0);
      chk("rst.mem_wen",    {31'd0, mem_wen},    32'd0);
      chk("rst.mem_waddr",  mem_waddr, 32'd0);
      chk("rst.mem_wdata",  mem_wdata, 32'd0);
      chk("rst.mem_raddr",  mem_raddr, 32'h0000_0104);
      rst = 1'b0;
      step();

      // Seed memory through the controller, including the last legal word.
      do_req("sw_seed",  1'b1, 3'b010, 32'h0000_0100, 32'h4433_2211, 3, 32'd0, 1'b0, 1);
      chk("sw_seed.wdata", last_wdata, 32'h4433_2211);
      do_req("sw_top",   1'b1, 3'b010, MEM_SIZE - 4, 32'hCAFE_F00D, 3, 32'd0, 1'b0, 1);
      chk("sw_top.waddr", last_waddr, 32'h000F_FFFC);

      do_req("lw_100",   1'b0, 3'b010, 32'h0000_0100, 32'd0, 1, 32'h4433_2211, 1'b0, 0);
      do_req("lw_top",   1'b0, 3'b010, MEM_SIZE - 4, 32'd0, 1, 32'hCAFE_F00D, 1'b0, 0);

      do_req("sb_101",   1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 3, 32'd0, 1'b0, 1);
      chk("sb_101.waddr", last_waddr, 32'h0000_0100);
      chk("sb_101.wdata", last_wdata, 32'h4433_AB11);
      do_req("lbu_101",  1'b0, 3'b100, 32'h0000_0101, 32'd0, 1, 32'h0000_00AB, 1'b0, 0);
      do_req("lb_101",   1'b0, 3'b000, 32'h0000_0101, 32'd0, 1, 32'hFFFF_FFAB, 1'b0, 0);

      do_req("sw_reseed", 1'b1, 3'b010, 32'h0000_0100, 32'h4433_2211, 3, 32'd0, 1'b0, 1);
      do_req("sh_102",   1'b1, 3'b001, 32'h0000_0102, 32'h0000_8001, 3, 32'd0, 1'b0, 1);
      chk("sh_102.wdata", last_wdata, 32'h8001_2211);
      do_req("lh_102",   1'b0, 3'b001, 32'h0000_0102, 32'd0, 1, 32'hFFFF_8001, 1'b0, 0);
      do_req("lhu_102",  1'b0, 3'b101, 32'h0000_0102, 32'd0, 1, 32'h0000_8001, 1'b0, 0);
      do_req("lb_103",   1'b0, 3'b000, 32'h0000_0103, 32'd0, 1, 32'hFFFF_FF80, 1'b0, 0);

      do_req("err_lw102",  1'b0, 3'b010, 32'h0000_0102, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("err_sh103",  1'b1, 3'b001, 32'h0000_0103, 32'h0000_FFFF, 1, 32'd0, 1'b1, 0);
      do_req("err_lwtop",  1'b0, 3'b010, MEM_SIZE - 2, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("err_range",  1'b0, 3'b010, MEM_SIZE, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("err_f3ld",   1'b0, 3'b011, 32'h0000_0100, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("err_f3st",   1'b1, 3'b100, 32'h0000_0100, 32'h0000_0055, 1, 32'd0, 1'b1, 0);
      do_req("lw_after_err", 1'b0, 3'b010, 32'h0000_0100, 32'd0, 1, 32'h8001_2211, 1'b0, 0);

      // Response back-pressure: held for five cycles, accepted on the sixth.
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0100;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold.resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("hold.rdata", resp_rdata, 32'h8001_2211);
         chk("hold.req_ready", {31'd0, req_ready}, 32'd0);
         step();
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("hold.release_valid", {31'd0, resp_valid}, 32'd0);
      chk("hold.release_ready", {31'd0, req_ready}, 32'd1);

      // Reset landing in WR_SETTLE of a SW: the write already sampled still commits.
      begin
         int w0;
         w0         = wen_cnt;
         req_valid  = 1'b1;
         req_we     = 1'b1;
         req_funct3 = 3'b010;
         req_addr   = 32'h0000_0200;
         req_wdata  = 32'h1234_5678;
         step();
         req_valid = 1'b0;
         chk("rstmid.wen_issue", {31'd0, mem_wen}, 32'd1);
         step();
         rst = 1'b1;
         step();
         rst = 1'b0;
         chk("rstmid.resp_valid", {31'd0, resp_valid}, 32'd0);
         chk("rstmid.mem_wen", {31'd0, mem_wen}, 32'd0);
         chk("rstmid.req_ready", {31'd0, req_ready}, 32'd1);
         chk("rstmid.wen_pulses", 32'(wen_cnt - w0), 32'd1);
      end
      do_req("lw_after_rst", 1'b0, 3'b010, 32'h0000_0200, 32'd0, 1, 32'h1234_5678, 1'b0, 0);

      chk("wen_never_consecutive", 32'(wen_consec), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_lsu_ctrl.md
Name: mem_lsu_ctrl

Overview:
- Sequences load/store requests from the load-store unit onto the shared byte-addressed data memory.
- The memory offers combinational word reads on a read port and full-word writes only. Its write inputs are registered on the clk posedge and committed on the following negedge.
- This controller does sign/zero extension for loads, read-modify-write for SB/SH, alignment and range checks, and write-settle sequencing, so a load issued right after a store never reads stale data.
- Sits between the LSU and the memory's second read port and its write port.

Parameters:
- MEM_SIZE, 1048576: memory size in bytes; a request is in range only if addr+3 < MEM_SIZE.
- WIDTH, 32: data word width; only 32 is supported.

Ports:
- clk  in  1  single clock for all state; also drives the memory's clk and w_clk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  LSU request valid.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (the last two are loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response valid; held until accepted.
- resp_ready  in  1  LSU accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- mem_raddr  out  32  word-aligned read address to the memory read port.
- mem_rdata  in  32  combinational read data from the memory.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  32  word-aligned write address.
- mem_wdata  out  32  full write word.

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_waddr=0, mem_wdata=0. mem_raddr = {req_addr[31:2],2'b00} always, i.e. combinational.
- States: IDLE, WR_ISSUE, WR_SETTLE, RESP.
- IDLE, on req_valid & req_ready (accept):
  - Latch the aligned address, byte offset addr[1:0], funct3, we and wdata.
  - Capture mem_rdata into old_word.
  - Evaluate the error condition:
    - funct3 not in the legal set for the request type;
    - H/HU with addr[0]=1;
    - W with addr[1:0]!=0;
    - aligned addr+3 >= MEM_SIZE.
  - Error -> RESP with resp_err=1 and resp_rdata=0; no memory write.
  - Legal load -> RESP. resp_rdata is old_word shifted right by 8*offset, then sign-extended (B, H) or zero-extended (BU, HU); W passes through unchanged.
  - Legal store -> WR_ISSUE.
- WR_ISSUE: exactly one cycle.
  - mem_wen=1, mem_waddr=aligned addr.
  - mem_wdata: SW = wdata; SH/SB = old_word with lane(s) at the offset replaced by wdata[15:0] or wdata[7:0].
  - Next state is WR_SETTLE.
- WR_SETTLE: one cycle.
  - mem_wen=0. The memory commits on the negedge inside this cycle.
  - Next state is RESP.
- RESP:
  - resp_valid=1 and resp_rdata/resp_err are held stable.
  - On resp_ready, go to IDLE and clear resp_valid the next cycle.
  - There is no combinational req_ready->resp path, so back-to-back requests have at least one idle cycle between them.
- Latency from accept to resp_valid: load/error = 1 cycle; store = 3 cycles.
- mem_wen is asserted in WR_ISSUE only and never for more than one consecutive cycle.
- Reset mid-operation: the next state is IDLE and mem_wen=0 from the next cycle, so no new write is issued. A write already sampled by the memory in WR_ISSUE at the reset edge still commits; that is accepted behaviour.
- Requests presented while req_ready=0 are ignored; the LSU must hold them.

Test Plan:
- Reset, then LW at 0x100 where memory holds bytes 11 22 33 44 -> resp_valid 1 cycle after accept; resp_rdata=0x44332211; resp_err=0.
- SB 0xAB to 0x101 (word 0x44332211) -> one mem_wen pulse with mem_waddr=0x100 and mem_wdata=0x4433AB11; resp_valid 3 cycles after accept. A following LBU at 0x101 returns 0x000000AB; LB at 0x101 returns 0xFFFFFFAB.
- SH 0x8001 to 0x102, then LH at 0x102 -> store writes 0x800122 11-merged word 0x80012211; load returns 0xFFFF8001. LHU returns 0x00008001.
- Misaligned LW at 0x102, SH at 0x103, and LW at MEM_SIZE-2 -> resp_err=1, resp_rdata=0, no mem_wen pulse.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid/resp_rdata stable and req_ready=0 throughout; accept on cycle 6, then IDLE.
- Assert rst during WR_SETTLE of an SW -> next cycle IDLE, resp_valid=0, mem_wen=0; the write of that SW is present in memory; the following request is serviced normally.
